// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the nibble-serial adder and its siblings.
//   state_e          : FSM state encoding (idle / run)
//   NIB              : bits processed per serial step
//   signed_overflow  : two's-complement overflow from operand and result MSBs
package arith_pkg;

  localparam int unsigned NIB = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Overflow when both operands share a sign and the result's sign differs.
  function automatic logic signed_overflow(input logic a_msb,
                                           input logic b_msb,
                                           input logic res_msb);
    return (a_msb == b_msb) && (res_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_add.sv
// Combinational NIB-bit adder slice with carry-in and carry-out.
//   i_a, i_b : NIB-bit addends
//   i_cin    : carry-in
//   o_sum    : low NIB bits of i_a + i_b + i_cin
//   o_cout   : carry out of the slice
module nibble_add
  import arith_pkg::*;
(
  input  logic [NIB-1:0] i_a,
  input  logic [NIB-1:0] i_b,
  input  logic           i_cin,
  output logic [NIB-1:0] o_sum,
  output logic           o_cout
);

  logic [NIB:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{NIB{1'b0}}, i_cin};
  assign o_sum  = w_full[NIB-1:0];
  assign o_cout = w_full[NIB];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle two's-complement adder: sums two WIDTH-bit operands plus carry-in,
// one nibble per clock, carrying between steps through a register.
//   i_clk      : rising-edge clock
//   i_rst_n    : synchronous active-low reset
//   i_start    : request, accepted only while idle (includes the done cycle)
//   i_a, i_b   : operands, captured with an accepted request
//   i_cin      : carry-in, captured with an accepted request
//   o_busy     : addition in progress
//   o_done     : one-cycle pulse when the result registers update
//   o_sum      : (a + b + cin) mod 2^WIDTH, held between additions
//   o_cout     : carry out of the MSB
//   o_overflow : signed overflow of the addition
module nibble_serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int unsigned N     = WIDTH / NIB;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((WIDTH % NIB) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e r_state;
  state_e w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;

  logic             w_accept;
  logic             w_running;
  logic             w_last;
  logic [NIB-1:0]   w_nib_a;
  logic [NIB-1:0]   w_nib_b;
  logic [NIB-1:0]   w_nib_sum;
  logic             w_nib_cout;
  logic [WIDTH-1:0] w_work_nxt;

  // The done cycle is spent in idle, so a request held across done is taken
  // on the very next edge.
  assign w_running = (r_state == StRun);
  assign w_accept  = (r_state == StIdle) && i_start;
  assign w_last    = w_running && (r_idx == LAST_IDX);

  assign w_nib_a = r_a[int'(r_idx) * NIB +: NIB];
  assign w_nib_b = r_b[int'(r_idx) * NIB +: NIB];

  nibble_add u_nibble_add (
    .i_a    (w_nib_a),
    .i_b    (w_nib_b),
    .i_cin  (r_carry),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout)
  );

  // Working register with the current nibble merged in; on the last step this
  // is the complete result.
  always_comb begin
    w_work_nxt = r_work;
    w_work_nxt[int'(r_idx) * NIB +: NIB] = w_nib_sum;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_carry <= i_cin;
        r_idx   <= '0;
      end else if (w_running) begin
        r_work  <= w_work_nxt;
        r_carry <= w_nib_cout;
        if (w_last) begin
          r_idx  <= '0;
          r_sum  <= w_work_nxt;
          r_cout <= w_nib_cout;
          r_ovf  <= signed_overflow(r_a[WIDTH-1], r_b[WIDTH-1], w_work_nxt[WIDTH-1]);
          r_done <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign o_busy     = w_running;
  assign o_done     = r_done;
  assign o_sum      = r_sum;
  assign o_cout     = r_cout;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_a        (a),
    .i_b        (b),
    .i_cin      (cin),
    .o_busy     (busy),
    .o_done     (done),
    .o_sum      (sum),
    .o_cout     (cout),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           done_at;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;

  int edges     = 0;
  int next_free = 0;
  int n_checks  = 0;
  int n_errors  = 0;
  bit mon_en    = 1'b0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edges, act, req);
    end
  endtask

  // Reference: plain wide arithmetic from the operand values.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input int at);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = full[W-1:0];
    e.c = full[W];
    e.v = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    e.done_at = at;
    return e;
  endfunction

  // Called at posedge+1; drives for one cycle and accounts for acceptance.
  task automatic drive(input logic st, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci);
    int e;
    start = st;
    a = x;
    b = y;
    cin = ci;
    @(posedge clk);
    #1;
    e = edges;
    if (st && e >= next_free) begin
      exp_q.push_back(model(x, y, ci, e + N));
      next_free = e + N + 1;
    end
  endtask

  task automatic do_reset();
    int e;
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    e = edges;
    exp_q.delete();
    held = '{s: '0, c: 1'b0, v: 1'b0, done_at: 0};
    next_free = e + 1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
  endtask

  // Monitor: decides per cycle whether a result is due and checks outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].done_at == edges) begin
        held = exp_q.pop_front();
        chk("done", 32'(done), 32'd1);
      end else begin
        chk("done", 32'(done), 32'd0);
      end
      chk("busy", 32'(busy), 32'(edges < next_free - 1));
      chk("sum", 32'(sum), 32'(held.s));
      chk("cout", 32'(cout), 32'(held.c));
      chk("overflow", 32'(ovf), 32'(held.v));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    held = '{s: '0, c: 1'b0, v: 1'b0, done_at: 0};
    do_reset();
    mon_en = 1'b1;
    idle(2);

    // Directed corner cases.
    drive(1'b1, 16'h0003, 16'h0004, 1'b0); idle(N + 1);
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0); idle(N + 1);
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0); idle(N + 1);
    drive(1'b1, 16'h8000, 16'h8000, 1'b1); idle(N + 1);

    // Ignored start while busy, then start held across done.
    drive(1'b1, 16'h1234, 16'h1111, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 2 * (N + 1); i++) drive(1'b1, 16'h0F0F, 16'h00F1, 1'b0);
    idle(N + 2);

    // Reset in the third run cycle abandons the addition.
    drive(1'b1, 16'hABCD, 16'h1234, 1'b1);
    idle(2);
    do_reset();
    idle(N + 3);
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0); idle(N + 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom));
      end
    end

    idle(N + 2);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
